chan_arbiter: RTL and testbench

- Reading end of the per-channel give/have/dout block interface.
- Polls NCH channel output FIFOs round-robin and pulls whole blocks (control word + L words), one block at a time.
- Forwards each block as a framed 16-bit stream (valid/ready, sop/eop) toward the link/readout path.
- Checks block framing; flags format and timeout errors.

---
 rtl/chan_arbiter_pkg.sv | 23 ++
 rtl/chan_arbiter_rr_pointer.sv | 19 +
 rtl/chan_arbiter.sv | 155 +++++++++++++++
 tb/tb_chan_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_arbiter_pkg.sv
// Shared definitions for the channel-FIFO block arbiter: FSM encoding and
// control-word field layout.
package chan_arbiter_pkg;

   localparam logic [1:0] ST_SCAN  = 2'd0;
   localparam logic [1:0] ST_DATA  = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

   localparam int CW_FLAG   = 15;
   localparam int CW_LEN_W  = 9;
   localparam int CW_CH_LSB = 9;
   localparam int CW_CH_MSB = 14;
   localparam int TMO_DEF   = 255;

   function automatic logic is_cw(input logic [15:0] w);
      return w[CW_FLAG];
   endfunction

   function automatic logic [CW_LEN_W-1:0] cw_len(input logic [15:0] w);
      return w[CW_LEN_W-1:0];
   endfunction

endpackage

// File: rtl/chan_arbiter_rr_pointer.sv
// Round-robin channel index: advances with wrap at NCH-1, otherwise holds.
module chan_arbiter_rr_pointer #(
   parameter int NCH = 16,
   parameter int CHW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           adv,
   output logic [CHW-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= '0;
      else if (adv)
         ptr <= (ptr == CHW'(NCH-1)) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/chan_arbiter.sv
// Polls channel output FIFOs round-robin and forwards whole blocks
// (control word + L words) as a framed 16-bit stream.
module chan_arbiter
   import chan_arbiter_pkg::*;
#(
   parameter int NCH = 16,
   parameter int CHW = 4,
   parameter int TMO = TMO_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    have,
   input  logic [16*NCH-1:0] dout,
   output logic [NCH-1:0]    give,
   output logic [15:0]       odata,
   output logic              ovalid,
   input  logic              oready,
   output logic              osop,
   output logic              oeop,
   output logic [CHW-1:0]    ochan,
   output logic              fmt_err,
   output logic              tmo_err,
   output logic [15:0]       blk_cnt
);

   logic [1:0]          state, state_n;
   logic [CHW-1:0]      ptr;
   logic [CW_LEN_W-1:0] left, left_n;
   logic [7:0]          tmo_cnt, tmo_n;
   logic [15:0]         word;
   logic ofree, give_en, hv, consume, adv;
   logic emit, emit_sop, emit_eop, fmt_p, tmo_p, blk_inc;

   assign ofree   = ~ovalid | oready;
   // rst_n gating keeps every request low while the block is held in reset
   assign give_en = rst_n & ofree & (state != ST_ABORT);
   assign consume = give_en & hv;

   always_comb begin
      give = '0;
      word = '0;
      hv   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (ptr == CHW'(i)) begin
            give[i] = give_en;
            word    = dout[16*i +: 16];
            hv      = have[i];
         end
      end
   end

   chan_arbiter_rr_pointer #(.NCH(NCH), .CHW(CHW)) u_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .ptr   (ptr)
   );

   always_comb begin
      state_n  = state;
      left_n   = left;
      tmo_n    = tmo_cnt;
      adv      = 1'b0;
      emit     = 1'b0;
      emit_sop = 1'b0;
      emit_eop = 1'b0;
      fmt_p    = 1'b0;
      tmo_p    = 1'b0;
      blk_inc  = 1'b0;
      case (state)
         ST_SCAN: begin
            if (consume) begin
               if (is_cw(word)) begin
                  emit     = 1'b1;
                  emit_sop = 1'b1;
                  left_n   = cw_len(word);
                  tmo_n    = '0;
                  if (cw_len(word) == '0) begin
                     emit_eop = 1'b1;
                     fmt_p    = 1'b1;
                     adv      = 1'b1;
                  end else begin
                     state_n = ST_DATA;
                  end
               end else begin
                  // stray data word: drop it and wait here for the next control word
                  fmt_p = 1'b1;
               end
            end else if (give_en) begin
               adv = 1'b1;
            end
         end
         ST_DATA: begin
            if (consume) begin
               emit   = 1'b1;
               left_n = left - 1'b1;
               tmo_n  = '0;
               if (left == CW_LEN_W'(1)) begin
                  emit_eop = 1'b1;
                  blk_inc  = 1'b1;
                  adv      = 1'b1;
                  state_n  = ST_SCAN;
               end
            end else if (give_en) begin
               if (tmo_cnt == 8'(TMO-1)) begin
                  tmo_p   = 1'b1;
                  adv     = 1'b1;
                  tmo_n   = '0;
                  state_n = ST_ABORT;
               end else begin
                  tmo_n = tmo_cnt + 8'd1;
               end
            end
         end
         default: state_n = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_SCAN;
         left    <= '0;
         tmo_cnt <= '0;
         odata   <= '0;
         ovalid  <= 1'b0;
         osop    <= 1'b0;
         oeop    <= 1'b0;
         ochan   <= '0;
         fmt_err <= 1'b0;
         tmo_err <= 1'b0;
         blk_cnt <= '0;
      end else begin
         state   <= state_n;
         left    <= left_n;
         tmo_cnt <= tmo_n;
         fmt_err <= fmt_p;
         tmo_err <= tmo_p;
         if (blk_inc)
            blk_cnt <= blk_cnt + 16'd1;
         if (emit) begin
            ovalid <= 1'b1;
            odata  <= word;
            osop   <= emit_sop;
            oeop   <= emit_eop;
            if (emit_sop)
               ochan <= ptr;
         end else if (ofree) begin
            ovalid <= 1'b0;
            osop   <= 1'b0;
            oeop   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: FIFO-backed channel models feed blocks,
// a negedge monitor records every accepted output word.
module tb_chan_arbiter;

   localparam int NCH = 16;
   localparam int CHW = 4;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b0;
   logic              oready = 1'b1;
   logic [NCH-1:0]    have, give;
   logic [16*NCH-1:0] dout;
   logic [15:0]       odata, blk_cnt;
   logic              ovalid, osop, oeop, fmt_err, tmo_err;
   logic [CHW-1:0]    ochan;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [NCH][64];
   int          wptr [NCH] = '{default: 0};
   int          rptr [NCH] = '{default: 0};
   logic [21:0] cap [$];
   int          n_fmt = 0, n_tmo = 0, viol = 0;
   bit          clr = 1'b0;

   always #4 clk = ~clk;

   chan_arbiter #(.NCH(NCH), .CHW(CHW), .TMO(255)) dut (
      .clk(clk), .rst_n(rst_n), .have(have), .dout(dout), .give(give),
      .odata(odata), .ovalid(ovalid), .oready(oready), .osop(osop), .oeop(oeop),
      .ochan(ochan), .fmt_err(fmt_err), .tmo_err(tmo_err), .blk_cnt(blk_cnt)
   );

   // channel model: have only while give is high and a word is queued
   always_comb begin
      have = '0;
      dout = '0;
      for (int i = 0; i < NCH; i++) begin
         have[i]          = give[i] && (rptr[i] != wptr[i]);
         dout[16*i +: 16] = mem[i][rptr[i] % 64];
      end
   end

   always @(posedge clk)
      for (int i = 0; i < NCH; i++)
         if (give[i] && have[i]) rptr[i] <= rptr[i] + 1;

   always @(negedge clk) begin
      if (clr) begin
         cap.delete();
         n_fmt = 0;
         n_tmo = 0;
         viol  = 0;
      end else if (rst_n) begin
         if (ovalid && oready) cap.push_back({osop, oeop, ochan, odata});
         if (fmt_err) n_fmt++;
         if (tmo_err) n_tmo++;
         if ((ovalid && !oready && give != '0) || $countones(give) > 1) viol++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [21:0] ent(input bit sop, input bit eop, input logic [3:0] ch,
                                       input logic [15:0] d);
      return {sop, eop, ch, d};
   endfunction

   task automatic push(input int ch, input logic [15:0] w);
      mem[ch][wptr[ch] % 64] = w;
      wptr[ch]++;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      oready = 1'b1;
      clr    = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_cap(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (cap.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (give !== '0)      begin errors++; $display("FAIL rst_give got %h exp 0", give); end
      checks++; if (ovalid !== 1'b0)  begin errors++; $display("FAIL rst_ovalid got %b exp 0", ovalid); end
      checks++; if (osop !== 1'b0 || oeop !== 1'b0) begin errors++; $display("FAIL rst_sop_eop got %b%b exp 00", osop, oeop); end
      checks++; if (odata !== 16'h0)  begin errors++; $display("FAIL rst_odata got %h exp 0", odata); end
      checks++; if (ochan !== '0)     begin errors++; $display("FAIL rst_ochan got %h exp 0", ochan); end
      checks++; if (fmt_err !== 1'b0 || tmo_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b exp 00", fmt_err, tmo_err); end
      checks++; if (blk_cnt !== 16'h0) begin errors++; $display("FAIL rst_blk_cnt got %h exp 0", blk_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (give !== 16'h0001) begin errors++; $display("FAIL rst_first_poll got %h exp 0001", give); end
   endtask

   task automatic test_basic();
      logic [21:0] exp [6];
      int k, run;
      do_reset();
      push(3, 16'h8605);
      for (int j = 1; j <= 5; j++) push(3, 16'h0100 + 16'(j));
      release_rst();
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ovalid) break;
      end
      checks++; if (k != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", k); end
      run = 1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (ovalid) run++;
      end
      checks++; if (run != 6) begin errors++; $display("FAIL basic_consecutive got %0d exp 6", run); end
      repeat (2) @(negedge clk);
      #1;
      exp[0] = ent(1, 0, 3, 16'h8605);
      for (int j = 1; j <= 4; j++) exp[j] = ent(0, 0, 3, 16'h0100 + 16'(j));
      exp[5] = ent(0, 1, 3, 16'h0105);
      checks++; if (cap.size() != 6) begin errors++; $display("FAIL basic_count got %0d exp 6", cap.size()); end
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (j >= cap.size() || cap[j] !== exp[j]) begin
            errors++;
            $display("FAIL basic_word%0d got %h exp %h", j, (j < cap.size()) ? cap[j] : 22'h0, exp[j]);
         end
      end
      checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL basic_blk_cnt got %0d exp 1", blk_cnt); end
   endtask

   task automatic test_two_chan();
      logic [21:0] exp [8];
      bit ok;
      do_reset();
      push(1, 16'h8203); push(1, 16'h0111); push(1, 16'h0112); push(1, 16'h0113);
      push(2, 16'h8403); push(2, 16'h0121); push(2, 16'h0122); push(2, 16'h0123);
      release_rst();
      wait_cap(8, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL two_chan_timeout got %0d words exp 8", cap.size()); end
      exp[0] = ent(1, 0, 1, 16'h8203); exp[1] = ent(0, 0, 1, 16'h0111);
      exp[2] = ent(0, 0, 1, 16'h0112); exp[3] = ent(0, 1, 1, 16'h0113);
      exp[4] = ent(1, 0, 2, 16'h8403); exp[5] = ent(0, 0, 2, 16'h0121);
      exp[6] = ent(0, 0, 2, 16'h0122); exp[7] = ent(0, 1, 2, 16'h0123);
      for (int j = 0; j < 8; j++) begin
         checks++;
         if (j >= cap.size() || cap[j] !== exp[j]) begin
            errors++;
            $display("FAIL two_chan_word%0d got %h exp %h", j, (j < cap.size()) ? cap[j] : 22'h0, exp[j]);
         end
      end
      checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL two_chan_blk_cnt got %0d exp 2", blk_cnt); end
   endtask

   task automatic test_backpressure();
      logic [21:0] exp [11];
      bit ok;
      do_reset();
      push(0, 16'h800A);
      for (int j = 1; j <= 10; j++) push(0, 16'h0A00 + 16'(j));
      release_rst();
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1 oready = (k % 2) == 1;
      end
      oready = 1'b1;
      wait_cap(11, 50, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (!ok || cap.size() != 11) begin errors++; $display("FAIL bp_count got %0d exp 11", cap.size()); end
      exp[0] = ent(1, 0, 0, 16'h800A);
      for (int j = 1; j <= 9; j++) exp[j] = ent(0, 0, 0, 16'h0A00 + 16'(j));
      exp[10] = ent(0, 1, 0, 16'h0A0A);
      for (int j = 0; j < 11; j++) begin
         checks++;
         if (j >= cap.size() || cap[j] !== exp[j]) begin
            errors++;
            $display("FAIL bp_word%0d got %h exp %h", j, (j < cap.size()) ? cap[j] : 22'h0, exp[j]);
         end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL bp_give_while_stalled got %0d exp 0", viol); end
      checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL bp_blk_cnt got %0d exp 1", blk_cnt); end
   endtask

   task automatic test_fmt();
      logic [21:0] exp [3];
      bit ok;
      do_reset();
      push(0, 16'h1234); push(0, 16'h8002); push(0, 16'h0201); push(0, 16'h0202);
      release_rst();
      wait_cap(3, 30, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (n_fmt != 1) begin errors++; $display("FAIL fmt_pulses got %0d exp 1", n_fmt); end
      checks++; if (!ok || cap.size() != 3) begin errors++; $display("FAIL fmt_count got %0d exp 3", cap.size()); end
      exp[0] = ent(1, 0, 0, 16'h8002); exp[1] = ent(0, 0, 0, 16'h0201); exp[2] = ent(0, 1, 0, 16'h0202);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (j >= cap.size() || cap[j] !== exp[j]) begin
            errors++;
            $display("FAIL fmt_word%0d got %h exp %h", j, (j < cap.size()) ? cap[j] : 22'h0, exp[j]);
         end
      end
      checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL fmt_blk_cnt got %0d exp 1", blk_cnt); end
   endtask

   task automatic test_len_zero();
      logic [21:0] exp [3];
      bit ok;
      do_reset();
      push(0, 16'h8000);
      push(1, 16'h8201); push(1, 16'h0111);
      release_rst();
      wait_cap(3, 30, ok);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (n_fmt != 1) begin errors++; $display("FAIL len0_fmt got %0d exp 1", n_fmt); end
      exp[0] = ent(1, 1, 0, 16'h8000); exp[1] = ent(1, 0, 1, 16'h8201); exp[2] = ent(0, 1, 1, 16'h0111);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (!ok || j >= cap.size() || cap[j] !== exp[j]) begin
            errors++;
            $display("FAIL len0_word%0d got %h exp %h", j, (j < cap.size()) ? cap[j] : 22'h0, exp[j]);
         end
      end
      checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL len0_blk_cnt got %0d exp 1", blk_cnt); end
   endtask

   task automatic test_timeout();
      int idle;
      bit seen;
      idle = 0;
      seen = 1'b0;
      do_reset();
      push(5, 16'h8A04); push(5, 16'h0501); push(5, 16'h0502);
      release_rst();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (tmo_err) begin
            seen = 1'b1;
            break;
         end
         if (give[5] && !have[5]) idle++;
      end
      checks++; if (!seen) begin errors++; $display("FAIL tmo_seen got 0 exp 1"); end
      checks++; if (idle != 255) begin errors++; $display("FAIL tmo_idle_cycles got %0d exp 255", idle); end
      checks++; if (give !== '0) begin errors++; $display("FAIL tmo_abort_give got %h exp 0", give); end
      @(negedge clk);
      #1;
      checks++; if (give !== 16'h0040) begin errors++; $display("FAIL tmo_resume got %h exp 0040", give); end
      checks++; if (tmo_err !== 1'b0 || n_tmo != 1) begin errors++; $display("FAIL tmo_pulse got %0d exp 1", n_tmo); end
      checks++;
      if (cap.size() != 3 || cap[2][20] !== 1'b0) begin
         errors++;
         $display("FAIL tmo_no_eop got %0d words exp 3 without eop", cap.size());
      end
      checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL tmo_blk_cnt got %0d exp 0", blk_cnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      push(0, 16'h8001); push(0, 16'h0011);
      push(1, 16'h820A);
      for (int j = 1; j <= 10; j++) push(1, 16'h0B00 + 16'(j));
      release_rst();
      wait_cap(5, 30, ok);
      checks++; if (!ok || blk_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre_blk_cnt got %0d exp 1", blk_cnt); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (give !== '0) begin errors++; $display("FAIL rmid_give_in_rst got %h exp 0", give); end
      @(posedge clk);
      #1;
      checks++; if (ovalid !== 1'b0 || osop !== 1'b0 || oeop !== 1'b0) begin errors++; $display("FAIL rmid_out got %b%b%b exp 000", ovalid, osop, oeop); end
      checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL rmid_blk_cnt got %0d exp 0", blk_cnt); end
      rst_n = 1'b1;
      #1;
      checks++; if (give !== 16'h0001) begin errors++; $display("FAIL rmid_scan_ptr0 got %h exp 0001", give); end
      repeat (4) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_two_chan();
      test_backpressure();
      test_fmt();
      test_len_zero();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
